// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file with trap/mret sequencing; optional mcycle via CSR_MCYCLE_EN
`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 8
`endif

module csr_file #(
    parameter logic [`XLEN-1:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [`HART_ID_W-1:0] hart_id,
    input  logic                  csr_req,
    input  logic [1:0]            csr_op,
    input  logic [11:0]           csr_addr,
    input  logic [`XLEN-1:0]      csr_wdata,
    output logic [`XLEN-1:0]      csr_rdata,
    output logic                  csr_illegal,
    input  logic                  trap_commit,
    input  logic [`XLEN-1:0]      trap_mepc,
    input  logic [`XLEN-1:0]      trap_mcause,
    input  logic                  mret,
    output logic [`XLEN-1:0]      mepc_o,
    output logic [`XLEN-1:0]      mtvec,
    output logic [`XLEN-1:0]      mstatus,
    output logic [`XLEN-1:0]      mie,
    output logic [`XLEN-1:0]      mip,
    input  logic                  ext_irq
);
    localparam int XLEN = `XLEN;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
`endif

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_meie_q, mie_meie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic            irq_meta_q, irq_sync_q;
`ifdef CSR_MCYCLE_EN
    logic [63:0]     mcycle_q, mcycle_d;
`endif

    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] wr_val;
    logic            mapped;
    logic            read_only;
    logic            wr_en;

    assign mstatus = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
    assign mie     = {{(XLEN-12){1'b0}}, mie_meie_q, 11'b0};
    assign mip     = {{(XLEN-12){1'b0}}, irq_sync_q, 11'b0};
    assign mtvec   = mtvec_q;
    assign mepc_o  = mepc_q;

    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:  rd_val = mstatus;
            ADDR_MIE:      rd_val = mie;
            ADDR_MTVEC:    rd_val = mtvec_q;
            ADDR_MSCRATCH: rd_val = mscratch_q;
            ADDR_MEPC:     rd_val = mepc_q;
            ADDR_MCAUSE:   rd_val = mcause_q;
            ADDR_MIP:      rd_val = mip;
            ADDR_MHARTID:  rd_val = {{(XLEN-`HART_ID_W){1'b0}}, hart_id};
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:   rd_val = mcycle_q[31:0];
            ADDR_MCYCLEH:  rd_val = mcycle_q[63:32];
`endif
            default:       mapped = 1'b0;
        endcase
    end

    assign read_only   = (csr_addr == ADDR_MHARTID) || (csr_addr == ADDR_MIP);
    assign csr_illegal = csr_req && (!mapped || ((csr_op != OP_READ) && read_only));
    assign csr_rdata   = csr_illegal ? '0 : rd_val;

    always_comb begin
        case (csr_op)
            OP_RW:   wr_val = csr_wdata;
            OP_RS:   wr_val = rd_val | csr_wdata;
            default: wr_val = rd_val & ~csr_wdata;
        endcase
    end

    // Trap entry and mret each suppress a same-cycle CSR write completely.
    assign wr_en = csr_req && !csr_illegal && (csr_op != OP_READ) && !trap_commit && !mret;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        if (trap_commit) begin
            mepc_d         = trap_mepc & ALIGN_MASK;
            mcause_d       = trap_mcause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = wr_val[3];
                    mstatus_mpie_d = wr_val[7];
                end
                ADDR_MIE:      mie_meie_d = wr_val[11];
                ADDR_MTVEC:    mtvec_d    = wr_val & ALIGN_MASK;
                ADDR_MSCRATCH: mscratch_d = wr_val;
                ADDR_MEPC:     mepc_d     = wr_val & ALIGN_MASK;
                ADDR_MCAUSE:   mcause_d   = wr_val;
                default: ;
            endcase
        end
    end

`ifdef CSR_MCYCLE_EN
    // A write to either half replaces it and skips that cycle's increment.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (wr_en && (csr_addr == ADDR_MCYCLE)) begin
            mcycle_d = {mcycle_q[63:32], wr_val};
        end else if (wr_en && (csr_addr == ADDR_MCYCLEH)) begin
            mcycle_d = {wr_val, mcycle_q[31:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q <= '0;
        end else begin
            mcycle_q <= mcycle_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST & ALIGN_MASK;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            irq_meta_q     <= 1'b0;
            irq_sync_q     <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            irq_meta_q     <= ext_irq;
            irq_sync_q     <= irq_meta_q;
        end
    end

endmodule
